fiapp_monitor: RTL and testbench

Cycle-accurate observer that sits directly downstream of the fiapp pipeline and consumes its o1/o2/o3 outputs alongside copies of its a/enable inputs. It runs a shadow model of the three-register stage and checks every output against it each cycle. Mismatches caused by injected SOI faults are recorded as sticky flags, a saturating count, and a first-error snapshot. An alarm is raised once the count reaches a threshold.

---
 rtl/fiapp_monitor.sv | 151 +++++++++++++++
 tb/tb_fiapp_monitor.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fiapp_monitor.sv
// Cycle-accurate observer for the fiapp three-register stage.
// Runs a shadow model and compares each fiapp output against it every cycle.
// Mismatches are recorded as sticky flags, a saturating count and a snapshot
// of the first failing cycle. The alarm is raised when the count reaches a threshold.
module fiapp_monitor #(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned TS_W         = 16,
  parameter int unsigned WARMUP       = 2,
  parameter int unsigned ALARM_THRESH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mon_en,
  input  logic             dut_a,
  input  logic             dut_enable,
  input  logic             dut_o1,
  input  logic             dut_o2,
  input  logic             dut_o3,
  input  logic             err_clear,
  output logic [2:0]       err_flags,
  output logic [CNT_W-1:0] err_count,
  output logic [2:0]       first_err_code,
  output logic [TS_W-1:0]  first_err_time,
  output logic             alarm,
  output logic             armed
);

  localparam int unsigned      WarmW    = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] Thresh   = CNT_W'(ALARM_THRESH);
  localparam logic [WarmW-1:0] WarmLoad = WarmW'(WARMUP);

  typedef enum logic [1:0] {StDisarmed, StWarmup, StArmed, StFault} state_e;

  state_e           state_q, state_d;
  logic [WarmW-1:0] warm_q, warm_d;
  logic             exp_q1_q, prev_o1_q, primed_q;
  logic [TS_W-1:0]  ts_q;
  logic [2:0]       flags_q, flags_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [2:0]       code_q, code_d;
  logic [TS_W-1:0]  time_q, time_d;
  logic             first_q, first_d;
  logic [2:0]       mis;
  logic             hit, rec;

  // Shadow model and timestamp run regardless of mon_en.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q1_q  <= 1'b0;
      prev_o1_q <= 1'b0;
      primed_q  <= 1'b0;
      ts_q      <= '0;
    end else begin
      if (dut_enable) exp_q1_q <= dut_a;
      prev_o1_q <= dut_o1;
      primed_q  <= 1'b1;
      ts_q      <= ts_q + TS_W'(1);
    end
  end

  // Checks on o2/o3 are masked until the shadow has seen one edge.
  assign mis[0] = dut_o1 ^ exp_q1_q;
  assign mis[1] = primed_q & (dut_o2 ^ prev_o1_q);
  assign mis[2] = primed_q & (dut_o3 ^ ~prev_o1_q);
  assign hit    = |mis;
  assign rec    = ((state_q == StArmed) || (state_q == StFault)) && hit;

  // Error recording; a clear wins over a same-cycle hit.
  always_comb begin
    flags_d = flags_q;
    count_d = count_q;
    code_d  = code_q;
    time_d  = time_q;
    first_d = first_q;
    if (err_clear) begin
      flags_d = '0;
      count_d = '0;
      code_d  = '0;
      time_d  = '0;
      first_d = 1'b0;
    end else if (rec) begin
      flags_d = flags_q | mis;
      if (count_q != CntMax) count_d = count_q + CNT_W'(1);
      if (!first_q) begin
        first_d = 1'b1;
        code_d  = mis;
        time_d  = ts_q;
      end
    end
  end

  // Arming FSM next-state; dropping mon_en always disarms.
  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    unique case (state_q)
      StDisarmed: begin
        if (mon_en) begin
          if (WARMUP == 0) begin
            state_d = StArmed;
          end else begin
            state_d = StWarmup;
            warm_d  = WarmLoad;
          end
        end
      end
      StWarmup: begin
        warm_d = warm_q - WarmW'(1);
        if (warm_q <= WarmW'(1)) state_d = StArmed;
      end
      StArmed: begin
        if (!err_clear && (count_d >= Thresh)) state_d = StFault;
      end
      StFault: begin
        if (err_clear) state_d = StArmed;
      end
      default: state_d = StDisarmed;
    endcase
    if (!mon_en) state_d = StDisarmed;
  end

  // State and recorded-error registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StDisarmed;
      warm_q  <= '0;
      flags_q <= '0;
      count_q <= '0;
      code_q  <= '0;
      time_q  <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      flags_q <= flags_d;
      count_q <= count_d;
      code_q  <= code_d;
      time_q  <= time_d;
      first_q <= first_d;
    end
  end

  assign err_flags      = flags_q;
  assign err_count      = count_q;
  assign first_err_code = code_q;
  assign first_err_time = time_q;
  assign alarm          = (state_q == StFault);
  assign armed          = (state_q == StArmed) || (state_q == StFault);

endmodule

// File: tb/tb_fiapp_monitor.sv
// Directed bench for fiapp_monitor: a behavioural fiapp drives the monitor,
// with per-cycle fault injection taken from a vector table.
module tb_fiapp_monitor;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic mon_en = 1'b1;
  logic a = 1'b1;
  logic en = 1'b1;
  logic err_clear = 1'b0;
  logic [2:0] inj = 3'b000;
  logic stick = 1'b0;
  logic q1, q2, q3;
  logic o1, o2, o3;

  logic [2:0]  flags, code;
  logic [7:0]  cnt;
  logic [15:0] tm;
  logic        alarm, armed;
  logic [2:0]  flags2, code2;
  logic [1:0]  cnt2;
  logic [15:0] tm2;
  logic        alarm2, armed2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Fault-free fiapp reference: q1 holds a when enabled, q2 = old q1, q3 = ~old q1.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
      q3 <= 1'b0;
    end else begin
      if (en) q1 <= a;
      q2 <= q1;
      q3 <= ~q1;
    end
  end

  assign o1 = q1 ^ inj[0];
  assign o2 = q2 ^ inj[1];
  assign o3 = stick ? o2 : (q3 ^ inj[2]);

  fiapp_monitor #(.CNT_W(8), .TS_W(16), .WARMUP(2), .ALARM_THRESH(4)) dut (
    .clk(clk), .reset_n(reset_n), .mon_en(mon_en), .dut_a(a), .dut_enable(en),
    .dut_o1(o1), .dut_o2(o2), .dut_o3(o3), .err_clear(err_clear),
    .err_flags(flags), .err_count(cnt), .first_err_code(code), .first_err_time(tm),
    .alarm(alarm), .armed(armed)
  );

  // Narrow-counter instance for saturation.
  fiapp_monitor #(.CNT_W(2), .TS_W(16), .WARMUP(2), .ALARM_THRESH(3)) dut2 (
    .clk(clk), .reset_n(reset_n), .mon_en(mon_en), .dut_a(a), .dut_enable(en),
    .dut_o1(o1), .dut_o2(o2), .dut_o3(o3), .err_clear(err_clear),
    .err_flags(flags2), .err_count(cnt2), .first_err_code(code2), .first_err_time(tm2),
    .alarm(alarm2), .armed(armed2)
  );

  typedef struct {
    logic [2:0]  inj;
    logic        stick;
    logic        clr;
    logic        men;
    logic [2:0]  flags;
    logic [7:0]  cnt;
    logic [1:0]  cnt2;
    logic [2:0]  code;
    logic [15:0] tm;
    logic        alarm;
    logic        armed;
  } vec_t;

  vec_t rows[$];

  task automatic add(input logic [2:0] i_inj, input logic i_st, input logic i_cl,
                     input logic i_me, input logic [2:0] e_fl, input int e_cn, input int e_cn2,
                     input logic [2:0] e_cd, input int e_tm, input logic e_al,
                     input logic e_ar);
    vec_t r;
    r.inj = i_inj; r.stick = i_st; r.clr = i_cl; r.men = i_me;
    r.flags = e_fl; r.cnt = 8'(e_cn); r.cnt2 = 2'(e_cn2); r.code = e_cd;
    r.tm = 16'(e_tm); r.alarm = e_al; r.armed = e_ar;
    rows.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " flags"}, 32'(flags), 0);
    chk({tag, " count"}, 32'(cnt), 0);
    chk({tag, " code"}, 32'(code), 0);
    chk({tag, " time"}, 32'(tm), 0);
    chk({tag, " alarm"}, 32'(alarm), 0);
    chk({tag, " armed"}, 32'(armed), 0);
    chk({tag, " count2"}, 32'(cnt2), 0);
    chk({tag, " flags2"}, 32'(flags2), 0);
    chk({tag, " armed2"}, 32'(armed2), 0);
  endtask

  initial begin
    // Edge numbers count from reset release; ts at edge N is N-1.
    for (int e = 1; e <= 10; e++) add(3'b000, 0, 0, 1, 3'b000, 0, 0, 3'b000, 0, 0, e >= 3);
    add(3'b001, 0, 0, 1, 3'b001, 1, 1, 3'b001, 10, 0, 1);
    for (int k = 0; k < 3; k++) add(3'b000, 0, 0, 1, 3'b111, 2, 2, 3'b001, 10, 0, 1);
    add(3'b000, 0, 1, 1, 3'b000, 0, 0, 3'b000, 0, 0, 1);
    for (int k = 1; k <= 4; k++)
      add(3'b000, 1, 0, 1, 3'b100, k, (k > 3) ? 3 : k, 3'b100, 15, k == 4, 1);
    add(3'b100, 0, 1, 1, 3'b000, 0, 0, 3'b000, 0, 0, 1);
    add(3'b000, 0, 0, 1, 3'b000, 0, 0, 3'b000, 0, 0, 1);
    for (int k = 1; k <= 6; k++)
      add(3'b100, 0, 0, 1, 3'b100, k, (k > 3) ? 3 : k, 3'b100, 21, k >= 4, 1);
    add(3'b000, 0, 0, 0, 3'b100, 6, 3, 3'b100, 21, 0, 0);
    add(3'b100, 0, 0, 1, 3'b100, 6, 3, 3'b100, 21, 0, 0);
    add(3'b000, 0, 0, 1, 3'b100, 6, 3, 3'b100, 21, 0, 0);
    add(3'b000, 0, 1, 1, 3'b000, 0, 0, 3'b000, 0, 0, 1);

    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    reset_n = 1'b1;

    for (int i = 0; i < rows.size(); i++) begin
      inj = rows[i].inj;
      stick = rows[i].stick;
      err_clear = rows[i].clr;
      mon_en = rows[i].men;
      step();
      chk($sformatf("e%0d flags", i + 1), 32'(flags), 32'(rows[i].flags));
      chk($sformatf("e%0d count", i + 1), 32'(cnt), 32'(rows[i].cnt));
      chk($sformatf("e%0d count2", i + 1), 32'(cnt2), 32'(rows[i].cnt2));
      chk($sformatf("e%0d code", i + 1), 32'(code), 32'(rows[i].code));
      chk($sformatf("e%0d time", i + 1), 32'(tm), 32'(rows[i].tm));
      chk($sformatf("e%0d alarm", i + 1), 32'(alarm), 32'(rows[i].alarm));
      chk($sformatf("e%0d armed", i + 1), 32'(armed), 32'(rows[i].armed));
    end
    inj = 3'b000; stick = 1'b0; err_clear = 1'b0; mon_en = 1'b1;

    // Five o3 mismatches, then an asynchronous reset mid-cycle.
    inj = 3'b100;
    repeat (5) step();
    inj = 3'b000;
    chk("pre-reset count", 32'(cnt), 5);
    chk("pre-reset count2", 32'(cnt2), 3);
    chk("pre-reset time", 32'(tm), 31);
    chk("pre-reset alarm", 32'(alarm), 1);
    #2 reset_n = 1'b0;
    #1;
    chk_zero("async reset");

    // Released with o2 corrupted on the first edge: masked, nothing recorded.
    inj = 3'b010;
    #1 reset_n = 1'b1;
    step();
    inj = 3'b000;
    chk("post-reset flags", 32'(flags), 0);
    chk("post-reset count", 32'(cnt), 0);
    repeat (3) step();
    chk("rearm flags", 32'(flags), 0);
    chk("rearm count", 32'(cnt), 0);
    chk("rearm armed", 32'(armed), 1);
    chk("rearm alarm", 32'(alarm), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
